// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and screen bounds shared by the raster generator and renderers
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [9:0] cnt_t;

    function automatic logic in_span(input cnt_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster outputs driven by vga_timing and consumed by sprite renderers
interface vga_timing_if;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [8:0] y;
    logic       pix_en;
    logic       animate;
    logic [7:0] frame;

    modport master (output hsync, vsync, de, x, y, pix_en, animate, frame);
    modport slave  (input  hsync, vsync, de, x, y, pix_en, animate, frame);
endinterface

// File: rtl/vga_timing_pix_tick.sv
// pix_tick: divides clk by CLK_DIV; tick advances the raster, pix_en marks the resulting pixel slot
module pix_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic res,
    output logic tick,
    output logic pix_en
);
    logic [3:0] div;

    assign tick = div == 4'(CLK_DIV - 1);

    // Divider wraps at CLK_DIV-1; pix_en is registered so it lines up with the decoded outputs
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            div    <= tick ? '0 : div + 4'd1;
            pix_en <= tick;
        end
    end
endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters, registered sync/de/x/y decode and per-frame animate strobe
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic           clk,
    input  logic           res,
    vga_timing_if.master   vga
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC - 1;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC - 1;

    logic tick;
    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_last;
    logic v_last;
    logic de_n;
    logic blank_start;

    pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
        .clk    (clk),
        .res    (res),
        .tick   (tick),
        .pix_en (vga.pix_en)
    );

    assign h_last      = h_cnt == 10'(H_TOT - 1);
    assign v_last      = v_cnt == 10'(V_TOT - 1);
    assign de_n        = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign blank_start = tick && (h_cnt == '0) && (v_cnt == 10'(V_ACTIVE));

    // Raster position: h advances per pixel slot, v advances on each h wrap
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            h_cnt <= h_last ? '0 : h_cnt + 10'd1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        end
    end

    // Decode the current position into registered outputs, one slot behind the counters
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            vga.hsync <= 1'b1;
            vga.vsync <= 1'b1;
            vga.de    <= 1'b0;
            vga.x     <= '0;
            vga.y     <= '0;
        end else if (tick) begin
            vga.hsync <= !in_span(h_cnt, HS_LO, HS_HI);
            vga.vsync <= !in_span(v_cnt, VS_LO, VS_HI);
            vga.de    <= de_n;
            vga.x     <= de_n ? h_cnt : '0;
            vga.y     <= de_n ? v_cnt[8:0] : '0;
        end
    end

    // One-clk animate pulse and frame count as the outputs enter vertical blank
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            vga.animate <= 1'b0;
            vga.frame   <= '0;
        end else begin
            vga.animate <= blank_start;
            if (blank_start) vga.frame <= vga.frame + 8'd1;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: three vga_timing configurations checked each clock against a closed-form raster model
module tb_vga_timing;
    localparam int D [3]  = '{2, 1, 3};
    localparam int HA [3] = '{640, 6, 6};
    localparam int HF [3] = '{16, 1, 1};
    localparam int HS [3] = '{96, 2, 2};
    localparam int HB [3] = '{48, 3, 3};
    localparam int VA [3] = '{480, 4, 4};
    localparam int VF [3] = '{10, 1, 1};
    localparam int VS [3] = '{2, 1, 1};
    localparam int VB [3] = '{33, 2, 2};

    logic clk;
    logic res;
    int k;
    int total;
    int passed;
    logic [31:0] act [3];

    vga_timing_if vif0 ();
    vga_timing_if vif1 ();
    vga_timing_if vif2 ();

    vga_timing #(.CLK_DIV(2)) dut0 (.clk(clk), .res(res), .vga(vif0));
    vga_timing #(.CLK_DIV(1), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
                 .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)) dut1 (.clk(clk), .res(res), .vga(vif1));
    vga_timing #(.CLK_DIV(3), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
                 .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)) dut2 (.clk(clk), .res(res), .vga(vif2));

    assign act[0] = {vif0.hsync, vif0.vsync, vif0.de, vif0.x, vif0.y, vif0.pix_en, vif0.animate, vif0.frame};
    assign act[1] = {vif1.hsync, vif1.vsync, vif1.de, vif1.x, vif1.y, vif1.pix_en, vif1.animate, vif1.frame};
    assign act[2] = {vif2.hsync, vif2.vsync, vif2.de, vif2.x, vif2.y, vif2.pix_en, vif2.animate, vif2.frame};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after k clock edges since reset release: slot n = k/D shows raster position n-1
    function automatic logic [31:0] model(input int d, input int kk);
        int ht, vt, ft, n, p, h, v, fr, blank;
        logic de, hs, vs, pe, an;
        ht = HA[d] + HF[d] + HS[d] + HB[d];
        vt = VA[d] + VF[d] + VS[d] + VB[d];
        ft = ht * vt;
        n = kk / D[d];
        if (n == 0) return {1'b1, 1'b1, 30'b0};
        p = (n - 1) % ft;
        h = p % ht;
        v = p / ht;
        blank = VA[d] * ht;
        de = (h < HA[d]) && (v < VA[d]);
        hs = !((h >= HA[d] + HF[d]) && (h < HA[d] + HF[d] + HS[d]));
        vs = !((v >= VA[d] + VF[d]) && (v < VA[d] + VF[d] + VS[d]));
        pe = (kk % D[d]) == 0;
        an = pe && (p == blank);
        fr = (n - 1 >= blank) ? ((n - 1 - blank) / ft + 1) : 0;
        return {hs, vs, de, de ? 10'(h) : 10'd0, de ? 9'(v) : 9'd0, pe, an, 8'(fr)};
    endfunction

    task automatic test_reset();
        res = 1'b0;
        k = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (act[d] !== model(d, 0))
                $display("FAIL reset dut%0d got %h want %h", d, act[d], model(d, 0));
            else passed++;
        end
        res = 1'b1;
    endtask

    task automatic test_first_line();
        int hs_low, de_high;
        hs_low = 0;
        de_high = 0;
        for (int c = 0; c < 1700; c++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k <= 1600 && !act[0][31]) hs_low++;
            if (k <= 1600 && act[0][29]) de_high++;
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d] !== model(d, k))
                    $display("FAIL line dut%0d k=%0d got %h want %h", d, k, act[d], model(d, k));
                else passed++;
            end
        end
        total++;
        if (hs_low !== 192) $display("FAIL hsync_width got %0d want 192 clocks", hs_low);
        else passed++;
        total++;
        if (de_high !== 1280) $display("FAIL de_width got %0d want 1280 clocks", de_high);
        else passed++;
    endtask

    task automatic test_frames();
        int anim, anim_de, wraps;
        logic [7:0] last_fr;
        anim = 0;
        anim_de = 0;
        wraps = 0;
        last_fr = act[1][7:0];
        for (int c = 0; c < 256 * 96; c++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (act[1][8]) anim++;
            for (int d = 0; d < 3; d++) if (act[d][8] && act[d][29]) anim_de++;
            if (last_fr == 8'd255 && act[1][7:0] == 8'd0) wraps++;
            last_fr = act[1][7:0];
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d] !== model(d, k))
                    $display("FAIL frames dut%0d k=%0d got %h want %h", d, k, act[d], model(d, k));
                else passed++;
            end
        end
        total++;
        if (anim !== 256) $display("FAIL animate_count got %0d want 256", anim);
        else passed++;
        total++;
        if (anim_de !== 0) $display("FAIL animate_in_de got %0d want 0", anim_de);
        else passed++;
        total++;
        if (wraps !== 1) $display("FAIL frame_wrap got %0d want 1", wraps);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        for (int r = 0; r < 3; r++) begin
            int run, hold;
            run = $urandom_range(600, 50);
            hold = $urandom_range(5, 1);
            for (int c = 0; c < run; c++) begin
                @(posedge clk);
                k++;
                @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    total++;
                    if (act[d] !== model(d, k))
                        $display("FAIL pre_reset dut%0d k=%0d got %h want %h", d, k, act[d], model(d, k));
                    else passed++;
                end
            end
            #($urandom_range(4, 1));
            res = 1'b0;
            k = 0;
            #1;
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d] !== model(d, 0))
                    $display("FAIL async_reset dut%0d got %h want %h", d, act[d], model(d, 0));
                else passed++;
            end
            repeat (hold) @(negedge clk);
            res = 1'b1;
            for (int c = 0; c < 400; c++) begin
                @(posedge clk);
                k++;
                @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    total++;
                    if (act[d] !== model(d, k))
                        $display("FAIL restart dut%0d k=%0d got %h want %h", d, k, act[d], model(d, k));
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_clkdiv1();
        int pe_cnt;
        pe_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (act[1][9]) pe_cnt++;
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d] !== model(d, k))
                    $display("FAIL clkdiv1 dut%0d k=%0d got %h want %h", d, k, act[d], model(d, k));
                else passed++;
            end
        end
        total++;
        if (pe_cnt !== 100) $display("FAIL pix_en_div1 got %0d want 100", pe_cnt);
        else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        k = 0;
        res = 1'b0;
        test_reset();
        test_first_line();
        test_frames();
        test_reset_midframe();
        test_clkdiv1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the tile-game display pipeline. It divides the system clock down to a pixel rate and runs horizontal and vertical counters for 640x480@60 timing. It produces the sync pulses and the `x`/`y`/`de` pixel coordinates consumed by every sprite renderer (health heart, tiles, score). It also generates the once-per-frame `animate` strobe that those renderers use to latch their APB-written state.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; legal values are 1 to 16.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`, input, 1: system clock; one clock domain only.
- `res`, input, 1: asynchronous, active-low reset.
- `hsync`, output, 1: horizontal sync, active-low.
- `vsync`, output, 1: vertical sync, active-low.
- `de`, output, 1: high while the current pixel is in the visible area.
- `x`, output, 10: pixel column, 0 to 639 while `de`=1; 0 otherwise.
- `y`, output, 9: pixel row, 0 to 479 while `de`=1; 0 otherwise.
- `pix_en`, output, 1: one-`clk` strobe that marks each pixel slot.
- `animate`, output, 1: one-`clk` pulse at the start of vertical blank.
- `frame`, output, 8: frame counter; increments with `animate` and wraps from 255 to 0.

## Operation
- Divider `div` (4 bits) counts 0 to `CLK_DIV`-1 and wraps. `pix_en` is high when `div`=`CLK_DIV`-1. With `CLK_DIV`=1, `pix_en` is high on every clock.
- `h_cnt` (10 bits) advances only on `pix_en`.
  - Range: 0 to `H_TOTAL`-1, where `H_TOTAL` = 800.
  - At `H_TOTAL`-1 it wraps to 0 and `v_cnt` advances.
- `v_cnt` (10 bits) has range 0 to `V_TOTAL`-1, where `V_TOTAL` = 525. It wraps to 0 together with `h_cnt` on the last pixel of the last line.
- Output decode is registered and is updated on `pix_en` cycles only:
  - `de` = (`h_cnt` < `H_ACTIVE`) & (`v_cnt` < `V_ACTIVE`).
  - `hsync`=0 while `h_cnt` is in [656, 751].
  - `vsync`=0 while `v_cnt` is in [490, 491].
  - `x` = `h_cnt`, and `y` = `v_cnt[8:0]`, when `de`; otherwise both are 0.
- `animate` is a one-`clk` pulse on the same edge at which the registered outputs first reflect (`h_cnt`=0, `v_cnt`=`V_ACTIVE`).
  - Renderers use it to latch new state; that state is then stable for all of the next visible frame.
  - `frame` increments on that same edge.
- Downstream colour mux must gate all sprite outputs with `de`, because `x`/`y`=0 during blanking would otherwise alias pixel (0,0).
- No run/stop input. The generator free-runs from reset release.

## Timing
- Reset (asynchronous assert, `res`=0) sets:
  - `div`=0, `h_cnt`=0, `v_cnt`=0
  - `hsync`=1, `vsync`=1, `de`=0
  - `x`=0, `y`=0
  - `pix_en`=0, `animate`=0, `frame`=0
- Release is synchronous to `clk`.
  - The first `pix_en` occurs `CLK_DIV` clocks after release.
  - On that edge `de` rises with `x`=0, `y`=0.
- Latency: the outputs describe the counter state of the previous `pix_en` edge. This is a fixed 1-pixel-slot lag, and it applies equally to sync, `de`, `x`, `y` and `animate`, so they stay mutually aligned.
- Line period is 800×`CLK_DIV` clocks. Frame period is 420000×`CLK_DIV` clocks.
- `animate` occurs exactly once per frame, and never while `de`=1.
- Reset asserted mid-frame: all state clears immediately and restarts as from power-up. Any partial `animate` pulse is truncated.
- Counter wrap and `animate` on the same edge cannot coincide, because `V_ACTIVE` < `V_TOTAL`.
- Arithmetic is unsigned. Totals are computed as parameter sums and must be at most 1023.

## Structure
- Package `vga_pkg` holds the 640x480 timing constants, the derived `H_TOTAL`/`V_TOTAL`, and the sync start/end positions; all renderers import it for the screen bounds.
- One sub-module, `pix_tick`: the `CLK_DIV` divider that produces `pix_en`.
- Counters, decode and frame counter live in `vga_timing`.

## Test plan
- Reset release, `CLK_DIV`=2 -> first `pix_en` at clock 2 after release. On that edge `de`=1, `x`=0, `y`=0, `hsync`=1, `vsync`=1.
- Run one line -> `de` high for 640 slots. `x` reaches 639, then drops to 0 with `de`=0. `hsync` is low for exactly 96 slots, starting 656 slots after `x`=0. Line length is 1600 clocks.
- Run one frame -> `vsync` low for 2 lines, starting at line 490. `animate` pulses once, one clock wide, immediately after the last pixel of line 479. `frame` goes 0→1. Frame length is 840000 clocks.
- Run 256 frames -> `frame` wraps from 255 to 0. Exactly 256 `animate` pulses are seen, and no `animate` occurs while `de`=1.
- Assert `res` at line 300, pixel 100 -> all outputs reach their reset values asynchronously. After release, timing restarts at (0,0) with no extra `animate`.
- `CLK_DIV`=1 -> `pix_en` is constantly 1 and line length is 800 clocks. All sync positions match the `CLK_DIV`=2 run, measured in pixel slots.
